// File: rtl/chase_step_gen.sv
// Step-clock and direction front end for the LED chaser: divides clk into step_clk,
// and synchronises/debounces the raw switches. Debounce latency 2 + DEB_CNT cycles;
// no backpressure. Optional manual single-stepping is built when MANUAL_STEP_EN is defined.

// Two-flop synchroniser followed by a counting debouncer for one raw input.
// The debounced value flips after the synchronised value has differed for DEB_CNT cycles.
module chase_step_deb #(
  parameter int unsigned DEB_CNT = 1_000_000,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic deb_o,
  output logic deb_nxt_o
);

  localparam int unsigned CW = $clog2(DEB_CNT + 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } deb_state_e;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q,   deb_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  deb_state_e    state;

  // Synchroniser flops and debounce state; the synchroniser resets to the
  // debounced reset value so no spurious change is seen right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      deb_q   <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  // The state is fully determined by whether the synchronised and debounced
  // values disagree, so it is decoded rather than stored.
  always_comb begin
    state = (sync2_q != deb_q) ? ST_CHECK : ST_STABLE;
  end

  // Next-state logic: count while differing, flip at the end of the window,
  // clear whenever the input returns to the debounced value.
  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    case (state)
      ST_CHECK: begin
        if (cnt_q == CW'(DEB_CNT - 1)) begin
          deb_d = sync2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign deb_o     = deb_q;
  assign deb_nxt_o = deb_d;

endmodule

module chase_step_gen #(
  parameter int unsigned DIV_HALF = 25_000_000,
  parameter int unsigned DEB_CNT  = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_dir,
  input  logic btn_step,
  input  logic sw_mode,
  output logic step_clk,
  output logic step,
  output logic dir
);

  localparam int unsigned PW = $clog2(DIV_HALF);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          step_clk_q, step_clk_d;
  logic          step_q, step_d;
  logic          dir_q, dir_d;

  logic          dir_deb_nxt;
  logic          unused_dir_deb;
  logic          manual;
  logic          btn_pulse;

  chase_step_deb #(
    .DEB_CNT (DEB_CNT),
    .RST_VAL (1'b1)
  ) u_deb_dir (
    .clk       (clk),
    .reset     (reset),
    .raw_i     (sw_dir),
    .deb_o     (unused_dir_deb),
    .deb_nxt_o (dir_deb_nxt)
  );

`ifdef MANUAL_STEP_EN
  logic mode_deb, mode_deb_nxt;
  logic btn_deb, btn_deb_nxt;

  chase_step_deb #(
    .DEB_CNT (DEB_CNT),
    .RST_VAL (1'b0)
  ) u_deb_mode (
    .clk       (clk),
    .reset     (reset),
    .raw_i     (sw_mode),
    .deb_o     (mode_deb),
    .deb_nxt_o (mode_deb_nxt)
  );

  chase_step_deb #(
    .DEB_CNT (DEB_CNT),
    .RST_VAL (1'b0)
  ) u_deb_btn (
    .clk       (clk),
    .reset     (reset),
    .raw_i     (btn_step),
    .deb_o     (btn_deb),
    .deb_nxt_o (btn_deb_nxt)
  );

  // Manual mode follows the registered debounced mode; a button edge only
  // counts if the mode is manual both now and in the next cycle, so an edge
  // coinciding with a switch back to auto is dropped.
  always_comb begin
    manual    = mode_deb;
    btn_pulse = mode_deb & mode_deb_nxt & btn_deb_nxt & ~btn_deb;
  end
`else
  logic unused_manual_in;

  assign unused_manual_in = btn_step | sw_mode;

  // Without manual stepping the block is permanently in auto mode.
  always_comb begin
    manual    = 1'b0;
    btn_pulse = 1'b0;
  end
`endif

  // Output and prescaler registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q  <= '0;
      step_clk_q <= 1'b0;
      step_q     <= 1'b0;
      dir_q      <= 1'b1;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      step_clk_q <= step_clk_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
    end
  end

  // Prescaler: toggle step_clk at terminal count; in manual mode the counter is
  // parked at 0 and step_clk is high only for the single cycle after a button edge.
  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    step_clk_d = step_clk_q;
    step_d     = 1'b0;
    if (manual) begin
      pre_cnt_d  = '0;
      step_clk_d = btn_pulse;
      step_d     = btn_pulse;
    end else if (pre_cnt_q == PW'(DIV_HALF - 1)) begin
      pre_cnt_d  = '0;
      step_clk_d = ~step_clk_q;
      step_d     = ~step_clk_q;
    end else begin
      pre_cnt_d  = pre_cnt_q + PW'(1);
    end
  end

  // dir only updates into a cycle where step_clk is low, so it is never
  // changing across a rising edge; changes during the high phase wait for the fall.
  always_comb begin
    dir_d = step_clk_d ? dir_q : dir_deb_nxt;
  end

  assign step_clk = step_clk_q;
  assign step     = step_q;
  assign dir      = dir_q;

endmodule

// File: tb/tb_chase_step_gen.sv
// Directed bench for chase_step_gen with DIV_HALF = 4, DEB_CNT = 3.
// Cycle k is the interval after the k-th rising edge following reset release.
module tb_chase_step_gen;

  localparam int unsigned DIV_HALF = 4;
  localparam int unsigned DEB_CNT  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sw_dir = 1'b1;
  logic btn_step = 1'b0;
  logic sw_mode = 1'b0;
  logic step_clk, step, dir;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  chase_step_gen #(
    .DIV_HALF (DIV_HALF),
    .DEB_CNT  (DEB_CNT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_dir   (sw_dir),
    .btn_step (btn_step),
    .sw_mode  (sw_mode),
    .step_clk (step_clk),
    .step     (step),
    .dir      (dir)
  );

  always #5 clk = ~clk;

  // Free-running auto-mode waveform after reset release.
  function automatic logic sc_exp(int k);
    return ((k / DIV_HALF) % 2) == 1;
  endfunction

  function automatic logic step_exp(int k);
    return (k >= DIV_HALF) && ((k % (2 * DIV_HALF)) == DIV_HALF);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    cyc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (step_clk !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_step_clk got=%b want=0", step_clk);
    end
    n_cmp++;
    if (step !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_step got=%b want=0", step);
    end
    n_cmp++;
    if (dir !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_dir got=%b want=1", dir);
    end
  endtask

  task automatic test_auto_period();
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      n_cmp++;
      if (step_clk !== sc_exp(k)) begin
        n_bad++;
        $display("FAIL auto_step_clk cyc=%0d got=%b want=%b", k, step_clk, sc_exp(k));
      end
      n_cmp++;
      if (step !== step_exp(k)) begin
        n_bad++;
        $display("FAIL auto_step cyc=%0d got=%b want=%b", k, step, step_exp(k));
      end
      n_cmp++;
      if (dir !== 1'b1) begin
        n_bad++;
        $display("FAIL auto_dir cyc=%0d got=%b want=1", k, dir);
      end
      tick();
    end
  endtask

  task automatic test_dir_glitch();
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      if (k == 2) sw_dir = 1'b0;
      if (k == 4) sw_dir = 1'b1;
      n_cmp++;
      if (dir !== 1'b1) begin
        n_bad++;
        $display("FAIL glitch_dir cyc=%0d got=%b want=1", k, dir);
      end
      tick();
    end
  endtask

  task automatic test_dir_change();
    logic want;
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      if (k == 5) sw_dir = 1'b0;
      want = (k < 10);
      n_cmp++;
      if (dir !== want) begin
        n_bad++;
        $display("FAIL change_dir cyc=%0d got=%b want=%b", k, dir, want);
      end
      n_cmp++;
      if (step_clk !== sc_exp(k)) begin
        n_bad++;
        $display("FAIL change_step_clk cyc=%0d got=%b want=%b", k, step_clk, sc_exp(k));
      end
      tick();
    end
    sw_dir = 1'b1;
  endtask

  // Debounced direction flips at cycle 5 in the high phase; dir waits for the fall at 8.
  task automatic test_dir_defer();
    logic want;
    do_reset();
    sw_dir = 1'b0;
    for (int k = 0; k <= 13; k++) begin
      want = (k < 8);
      n_cmp++;
      if (dir !== want) begin
        n_bad++;
        $display("FAIL defer_dir cyc=%0d got=%b want=%b", k, dir, want);
      end
      tick();
    end
    sw_dir = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (6) tick();
    n_cmp++;
    if (step_clk !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_pre step_clk got=%b want=1", step_clk);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (step_clk !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_step_clk got=%b want=0", step_clk);
    end
    n_cmp++;
    if (step !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_step got=%b want=0", step);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    cyc = 0;
    for (int k = 0; k <= 5; k++) begin
      n_cmp++;
      if (step_clk !== (k >= 4)) begin
        n_bad++;
        $display("FAIL midreset_rise cyc=%0d got=%b want=%b", k, step_clk, (k >= 4));
      end
      n_cmp++;
      if (step !== (k == 4)) begin
        n_bad++;
        $display("FAIL midreset_step_pulse cyc=%0d got=%b want=%b", k, step, (k == 4));
      end
      tick();
    end
  endtask

`ifdef MANUAL_STEP_EN
  // Mode goes manual at cycle 5 (the auto rise at 4 still happens and is cut
  // short at 6); a bouncy press starting at 8 yields one step at 17; returning
  // to auto at 30 gives the next rise at 39.
  task automatic test_manual();
    logic [9:0] pat;
    logic       want_sc, want_st;
    int         idx;
    pat = 10'b1111110101;
    sw_mode = 1'b1;
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      idx = k - 8;
      btn_step = (idx >= 0 && idx <= 9) ? pat[idx] : 1'b0;
      if (k == 30) sw_mode = 1'b0;
      want_sc = (k == 4) || (k == 5) || (k == 17) || (k >= 39);
      want_st = (k == 4) || (k == 17) || (k == 39);
      n_cmp++;
      if (step_clk !== want_sc) begin
        n_bad++;
        $display("FAIL manual_step_clk cyc=%0d got=%b want=%b", k, step_clk, want_sc);
      end
      n_cmp++;
      if (step !== want_st) begin
        n_bad++;
        $display("FAIL manual_step cyc=%0d got=%b want=%b", k, step, want_st);
      end
      tick();
    end
    btn_step = 1'b0;
  endtask
`else
  task automatic test_no_manual();
    sw_mode = 1'b1;
    do_reset();
    for (int k = 0; k <= 24; k++) begin
      btn_step = k[0];
      n_cmp++;
      if (step_clk !== sc_exp(k)) begin
        n_bad++;
        $display("FAIL nomanual_step_clk cyc=%0d got=%b want=%b", k, step_clk, sc_exp(k));
      end
      n_cmp++;
      if (step !== step_exp(k)) begin
        n_bad++;
        $display("FAIL nomanual_step cyc=%0d got=%b want=%b", k, step, step_exp(k));
      end
      tick();
    end
    btn_step = 1'b0;
    sw_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_auto_period();
    test_dir_glitch();
    test_dir_change();
    test_dir_defer();
    test_reset_mid();
`ifdef MANUAL_STEP_EN
    test_manual();
`else
    test_no_manual();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chase_step_gen.md
# chase_step_gen

Step-clock and direction front end for the LED chaser. It divides the board clock into a slow step clock, and 2-FF synchronises and debounces the direction switch. It optionally supports manual single-stepping from a push button. Its outputs `step_clk` and `dir` drive the chaser's clock and direction inputs directly.

## Interface
- `DIV_HALF`, default 25_000_000: half-period of `step_clk` in `clk` cycles (1 Hz from 50 MHz); must be ≥ 2.
- `DEB_CNT`, default 1_000_000: debounce stability window in `clk` cycles (20 ms at 50 MHz); must be ≥ 1.
- `clk` in 1: board clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sw_dir` in 1: raw direction switch (1 = forward).
- `btn_step` in 1: raw step push button, active-high; used only with `MANUAL_STEP_EN`.
- `sw_mode` in 1: raw mode switch (1 = manual); used only with `MANUAL_STEP_EN`.
- `step_clk` out 1: step clock for the chaser.
- `step` out 1: one-`clk`-cycle pulse, high in the cycle `step_clk` goes 0→1.
- `dir` out 1: debounced direction, stable around every `step_clk` rising edge.

## Operation
- **Reset values:**
  - `step_clk` = 0, `step` = 0, `dir` = 1.
  - Debounced values: dir = 1, btn = 0, mode = 0.
  - Prescaler and debounce counters = 0.
- **Synchroniser:** each raw input passes through two flops before any other use.
- **Debouncer:** one instance per raw input. Two states:
  - **STABLE:** synchronised value equals debounced value; counter held at 0.
  - **CHECK:** values differ; counter increments each cycle.
    - Counter reaches `DEB_CNT` − 1 while still differing: debounced value flips, counter clears, back to STABLE.
    - Values become equal again: counter clears, back to STABLE.
- **Prescaler (auto mode):**
  - Counter runs 0..`DIV_HALF` − 1.
  - At terminal count it wraps to 0 and toggles `step_clk`.
  - `step` is asserted in the same cycle that `step_clk` is set to 1.
- **`dir` register:**
  - Loads the debounced direction only in cycles where `step_clk` is 0 and no rising edge is being issued.
  - A direction change arriving while `step_clk` = 1 is deferred to the falling edge.
  - Result: `dir` is stable ≥ 1 `clk` cycle before every rising edge.
- **Counter widths:** `$clog2(DIV_HALF)` and `$clog2(DEB_CNT + 1)` bits. Counters are unsigned, with no overflow beyond terminal count.

## Timing
- **Prescaler:** after reset deassertion, the first `step_clk` rise occurs at cycle `DIV_HALF`, and the first fall at 2·`DIV_HALF`. Period is 2·`DIV_HALF`, 50 % duty.
- **Debounce latency:** a raw input change held stable from cycle 0 reaches the debounced value at cycle 2 + `DEB_CNT`.
  - Any bounce inside the window restarts the count.
- **`dir` latency:** debounced value plus 0 cycles if `step_clk` is low; otherwise updated in the cycle `step_clk` falls.
- **Reset mid-operation:** all outputs go to reset values immediately (asynchronous), even mid-high-phase. A partial debounce is discarded.

## Configuration
- **`MANUAL_STEP_EN` defined:** debounced mode = 1 selects manual mode.
  - **In manual mode:**
    - Prescaler held at 0 and `step_clk` held at 0.
    - Each debounced `btn_step` 0→1 edge produces exactly one `clk` cycle with `step_clk` = 1 and `step` = 1.
  - **Auto→manual:**
    - The prescaler clears.
    - If `step_clk` was high, it drops next cycle; this is not a new step.
  - **Manual→auto:** counting restarts from 0 with `step_clk` low; the first rise is `DIV_HALF` cycles later.
  - A button edge coinciding with a mode change to auto is ignored.
- **`MANUAL_STEP_EN` undefined:** `btn_step` and `sw_mode` are ignored, with no synchronisers or debouncers for them; the block is always in auto mode.

## Test plan
All scenarios use `DIV_HALF` = 4, `DEB_CNT` = 3.
1. Release reset with `sw_dir` = 1 → `step_clk` rises at cycles 4 and 12 and falls at 8; `step` is high only in cycles 4 and 12; `dir` = 1 throughout.
2. `sw_dir` pulses to 0 for 2 cycles then returns to 1 → `dir` never leaves 1.
3. `sw_dir` goes 1→0 at cycle 5 and holds → debounced value becomes 0 at cycle 10. With `step_clk` high during cycles 4–7 and low during 8–11, `dir` = 0 from cycle 10, before the rise at 12.
4. Assert `reset` at cycle 6 while `step_clk` = 1 → `step_clk` and `step` are 0 within the same cycle. After release, the next rise is 4 cycles later.
5. With `MANUAL_STEP_EN`: set `sw_mode` = 1, wait 6 cycles, then press `btn_step` for 10 cycles with 1-cycle bounces at the start → exactly one `step` pulse with `step_clk` high for 1 cycle, and no other rises.
6. Without `MANUAL_STEP_EN`: set `sw_mode` = 1 and toggle `btn_step` → `step_clk` keeps its 8-cycle period unchanged.
